// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection arbiter.
// Holds FSM encoding, score width and density code width.
package intersection_pkg;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_SELECT,
    S_WAIT_GREEN,
    S_WAIT_RED,
    S_FAULT
  } state_e;

  localparam int DENS_W  = 2;
  localparam int SCORE_W = 3;

  function automatic logic [SCORE_W-1:0] lane_score(
    input logic [DENS_W-1:0] dens,
    input logic              ped
  );
    return SCORE_W'(dens) + SCORE_W'(ped);
  endfunction

endpackage

// File: rtl/lane_picker.sv
// Combinational winner search over the lanes.
// Starved lanes win outright; round-robin from last_lane+1 breaks ties.
module lane_picker
  import intersection_pkg::*;
#(
  parameter int NUM_LANES = 4,
  localparam int IDX_W = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES*SCORE_W-1:0] score,
  input  logic [NUM_LANES-1:0]         cand,
  input  logic [NUM_LANES-1:0]         starved,
  input  logic [IDX_W-1:0]             last_lane,
  output logic [IDX_W-1:0]             winner,
  output logic                         valid
);

  logic [NUM_LANES-1:0] hungry;
  logic [NUM_LANES-1:0] pool;

  assign hungry = cand & starved;
  assign pool   = (|hungry) ? hungry : cand;

  // Scan from last_lane+1 with wrap; keep first strictly-best lane.
  always_comb begin
    int idx;
    int sc;
    int best;
    winner = '0;
    valid  = 1'b0;
    best   = 0;
    idx    = 0;
    sc     = 0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = (int'(last_lane) + k) % NUM_LANES;
      sc  = (|hungry) ? 0
          : int'(score[idx*SCORE_W +: SCORE_W]);
      if (pool[idx] && (!valid || sc > best)) begin
        valid  = 1'b1;
        best   = sc;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/intersection_arbiter.sv
// Intersection scheduler: picks a lane per round, grants it,
// tracks its light cycle and enforces all-red clearance.
module intersection_arbiter
  import intersection_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int TIMER_WIDTH   = 16,
  parameter int ALL_RED_TIME  = 5,
  parameter int MAX_WAIT      = 3,
  parameter int GRANT_TIMEOUT = 255,
  localparam int IDX_W  = $clog2(NUM_LANES),
  localparam int WAIT_W = $clog2(MAX_WAIT + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DENS_W*NUM_LANES-1:0]   density,
  input  logic [NUM_LANES-1:0]          ped_req,
  input  logic [NUM_LANES-1:0]          lane_green,
  input  logic [NUM_LANES-1:0]          lane_red,
  output logic [NUM_LANES-1:0]          grant,
  output logic [IDX_W-1:0]              active_lane,
  output logic                          busy,
  output logic                          fault
);

  state_e                          state_q, state_d;
  logic [TIMER_WIDTH-1:0]          timer_q, timer_d;
  logic [NUM_LANES-1:0]            grant_q, grant_d;
  logic [IDX_W-1:0]                active_q, active_d;
  logic [IDX_W-1:0]                last_q, last_d;
  logic                            busy_q, busy_d;
  logic                            fault_q, fault_d;
  logic [NUM_LANES-1:0][WAIT_W-1:0] wait_q, wait_d;

  logic [NUM_LANES*SCORE_W-1:0]    score;
  logic [NUM_LANES-1:0]            cand;
  logic [NUM_LANES-1:0]            starved;
  logic [NUM_LANES-1:0]            act_mask;
  logic [IDX_W-1:0]                pick;
  logic                            pick_ok;
  logic                            conflict;

  // Per-lane score, candidate and starvation flags.
  always_comb begin
    score   = '0;
    cand    = '0;
    starved = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      score[i*SCORE_W +: SCORE_W] =
        lane_score(density[DENS_W*i +: DENS_W], ped_req[i]);
      cand[i]    = (|density[DENS_W*i +: DENS_W]) | ped_req[i];
      starved[i] = wait_q[i] >= WAIT_W'(MAX_WAIT);
    end
  end

  lane_picker #(
    .NUM_LANES (NUM_LANES)
  ) u_picker (
    .score     (score),
    .cand      (cand),
    .starved   (starved),
    .last_lane (last_q),
    .winner    (pick),
    .valid     (pick_ok)
  );

  // Safety monitor: only the served lane may leave red.
  always_comb begin
    act_mask           = '0;
    act_mask[active_q] = 1'b1;
    conflict = (state_q != S_FAULT) &&
               ((|(~lane_red & ~act_mask)) ||
                (state_q == S_CLEAR && |lane_green));
  end

  // Next-state, timers, grant and wait-counter updates.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    grant_d  = '0;
    active_d = active_q;
    last_d   = last_q;
    busy_d   = busy_q;
    fault_d  = fault_q;
    wait_d   = wait_q;
    if (conflict) begin
      state_d = S_FAULT;
      busy_d  = 1'b0;
      fault_d = 1'b1;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          if (timer_q == '0 && &lane_red) begin
            state_d = S_SELECT;
          end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_SELECT: begin
          if (pick_ok) begin
            grant_d[pick] = 1'b1;
            active_d      = pick;
            last_d        = pick;
            busy_d        = 1'b1;
            timer_d       = '0;
            state_d       = S_WAIT_GREEN;
            for (int i = 0; i < NUM_LANES; i++) begin
              if (i == int'(pick) || !cand[i]) begin
                wait_d[i] = '0;
              end else if (!starved[i]) begin
                wait_d[i] = wait_q[i] + WAIT_W'(1);
              end
            end
          end
        end
        S_WAIT_GREEN: begin
          if (lane_green[active_q]) begin
            state_d = S_WAIT_RED;
          end else if (timer_q ==
                       TIMER_WIDTH'(GRANT_TIMEOUT)) begin
            state_d = S_FAULT;
            busy_d  = 1'b0;
            fault_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_WAIT_RED: begin
          if (lane_red[active_q]) begin
            state_d = S_CLEAR;
            timer_d = TIMER_WIDTH'(ALL_RED_TIME);
            busy_d  = 1'b0;
          end
        end
        S_FAULT: begin
          busy_d = 1'b0;
        end
        default: begin
          state_d = S_FAULT;
          busy_d  = 1'b0;
          fault_d = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_CLEAR;
      timer_q  <= TIMER_WIDTH'(ALL_RED_TIME);
      grant_q  <= '0;
      active_q <= '0;
      last_q   <= IDX_W'(NUM_LANES - 1);
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
      wait_q   <= wait_d;
    end
  end

  assign grant       = grant_q;
  assign active_lane = active_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_intersection_arbiter.sv
// Bench for intersection_arbiter: lane light models, a
// cycle-level reference model and directed scenarios.
module tb_intersection_arbiter;

  localparam int N   = 4;
  localparam int ART = 5;
  localparam int MW  = 2;
  localparam int GT  = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2*N-1:0] density = '0;
  logic [N-1:0] ped_req = '0;
  logic [N-1:0] lane_green;
  logic [N-1:0] lane_red;
  logic [N-1:0] grant;
  logic [1:0]   active_lane;
  logic         busy;
  logic         fault;

  logic [N-1:0] stub = '0;
  logic [N-1:0] f_notred = '0;
  logic [N-1:0] f_green = '0;
  logic [N-1:0] m_red = '1;
  logic [N-1:0] m_green = '0;

  int nchk = 0;
  int nfail = 0;
  int glog[$];

  always #5 clk = ~clk;

  intersection_arbiter #(
    .NUM_LANES     (N),
    .TIMER_WIDTH   (16),
    .ALL_RED_TIME  (ART),
    .MAX_WAIT      (MW),
    .GRANT_TIMEOUT (GT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .density     (density),
    .ped_req     (ped_req),
    .lane_green  (lane_green),
    .lane_red    (lane_red),
    .grant       (grant),
    .active_lane (active_lane),
    .busy        (busy),
    .fault       (fault)
  );

  assign lane_red   = m_red & ~f_notred;
  assign lane_green = m_green | f_green;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Lane light model: red-hold 2, green 3, yellow 2, then red.
  int lph[N];
  int lcnt[N];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        lph[i] = 0;
        lcnt[i] = 0;
      end else begin
        case (lph[i])
          0: if (grant[i] && !stub[i]) begin
               lph[i] = 1;
               lcnt[i] = 0;
             end
          1: begin
               lcnt[i]++;
               if (lcnt[i] == 2) begin lph[i] = 2; lcnt[i] = 0; end
             end
          2: begin
               lcnt[i]++;
               if (lcnt[i] == 3) begin lph[i] = 3; lcnt[i] = 0; end
             end
          default: begin
               lcnt[i]++;
               if (lcnt[i] == 2) begin lph[i] = 0; lcnt[i] = 0; end
             end
        endcase
      end
      m_red[i]   = (lph[i] <= 1);
      m_green[i] = (lph[i] == 2);
    end
  end

  // Reference model of the round rules, advanced each edge.
  localparam int P_CLR = 0, P_SEL = 1, P_WG = 2, P_WR = 3, P_FLT = 4;
  int ph, t, tc, ea, last, cyc;
  int wt[N];
  logic [N-1:0] eg;
  logic eb, ef;
  bit mvalid = 0;

  function automatic int model_pick();
    int best, bk, j, sc, key;
    best = -1;
    bk = -1;
    for (int k = 1; k <= N; k++) begin
      j  = (last + k) % N;
      sc = int'(density[2*j +: 2]) + int'(ped_req[j]);
      if (sc != 0) begin
        key = (wt[j] >= MW) ? 100 : sc;
        if (key > bk) begin
          bk = key;
          best = j;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk) begin
    bit viol;
    int w;
    mvalid = 1;
    if (reset) begin
      ph = P_CLR; t = ART; tc = 0; ea = 0; last = N - 1; cyc = 0;
      eg = '0; eb = 0; ef = 0;
      for (int i = 0; i < N; i++) wt[i] = 0;
    end else begin
      cyc++;
      eg = '0;
      viol = 0;
      if (ph != P_FLT) begin
        for (int j = 0; j < N; j++)
          if (j != ea && !lane_red[j]) viol = 1;
        if (ph == P_CLR && lane_green != '0) viol = 1;
      end
      if (viol) begin
        ph = P_FLT; eb = 0; ef = 1;
      end else begin
        case (ph)
          P_CLR: begin
            if (t == 0 && lane_red == '1) ph = P_SEL;
            else if (t > 0) t--;
          end
          P_SEL: begin
            w = model_pick();
            if (w >= 0) begin
              for (int j = 0; j < N; j++) begin
                if (j == w) wt[j] = 0;
                else if (density[2*j +: 2] != 0 || ped_req[j])
                  wt[j] = (wt[j] + 1 > MW) ? MW : wt[j] + 1;
                else wt[j] = 0;
              end
              eg[w] = 1'b1;
              ea = w; last = w; eb = 1; tc = 0; ph = P_WG;
            end
          end
          P_WG: begin
            if (lane_green[ea]) ph = P_WR;
            else if (tc == GT) begin ph = P_FLT; eb = 0; ef = 1; end
            else tc++;
          end
          P_WR: begin
            if (lane_red[ea]) begin ph = P_CLR; t = ART; eb = 0; end
          end
          default: eb = 0;
        endcase
      end
    end
  end

  // Every-cycle comparison of outputs against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("cyc_grant", 32'(grant), 32'(eg));
      chk("cyc_busy", 32'(busy), 32'(eb));
      chk("cyc_active", 32'(active_lane), 32'(ea));
      chk("cyc_fault", 32'(fault), 32'(ef));
    end
  end

  // Log of issued grants, as lane indices.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (grant[i]) glog.push_back(i);
  end

  task automatic do_reset(input logic [2*N-1:0] d,
                          input logic [N-1:0] p);
    @(negedge clk);
    reset = 1'b1;
    stub = '0;
    f_notred = '0;
    f_green = '0;
    density = d;
    ped_req = p;
    repeat (3) @(negedge clk);
    glog.delete();
    reset = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    int s, c;
    s = glog.size();
    c = 0;
    while (glog.size() < s + n && c < 3000) begin
      @(posedge clk);
      c++;
    end
    chk("wait_grants", 32'(glog.size() >= s + n), 32'd1);
  endtask

  initial begin
    int c;
    // First grant latency and busy span.
    do_reset(8'b00_00_11_01, 4'b0000);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) chk("rst_busy", 32'(busy), 32'd0);
      if (k == 6) chk("pre_grant", 32'(grant), 32'd0);
      if (k == 7) chk("first_grant", 32'(grant), 32'b0010);
    end
    c = 0;
    while (busy && c < 100) begin @(negedge clk); c++; end
    chk("busy_fall_red", 32'(lane_red[1]), 32'd1);
    chk("busy_fell", 32'(busy), 32'd0);

    // Equal densities rotate round-robin.
    do_reset(8'b10_10_10_10, 4'b0000);
    wait_grants(5);
    chk("tie_0", 32'(glog[0]), 32'd0);
    chk("tie_1", 32'(glog[1]), 32'd1);
    chk("tie_2", 32'(glog[2]), 32'd2);
    chk("tie_3", 32'(glog[3]), 32'd3);
    chk("tie_4", 32'(glog[4]), 32'd0);

    // Pedestrian boost tie with last_lane = 2.
    do_reset(8'b00_01_00_00, 4'b0000);
    wait_grants(1);
    @(negedge clk);
    density = 8'b10_01_00_00;
    ped_req = 4'b0100;
    wait_grants(1);
    chk("ped_a0", 32'(glog[0]), 32'd2);
    chk("ped_a1", 32'(glog[1]), 32'd3);

    // Pedestrian boost tie with last_lane = 1.
    do_reset(8'b00_00_01_00, 4'b0000);
    wait_grants(1);
    @(negedge clk);
    density = 8'b10_01_00_00;
    ped_req = 4'b0100;
    wait_grants(1);
    chk("ped_b0", 32'(glog[0]), 32'd1);
    chk("ped_b1", 32'(glog[1]), 32'd2);

    // Starvation forces the low-density lane.
    do_reset(8'b00_01_00_11, 4'b0000);
    wait_grants(3);
    chk("starve_0", 32'(glog[0]), 32'd0);
    chk("starve_1", 32'(glog[1]), 32'd0);
    chk("starve_2", 32'(glog[2]), 32'd2);

    // Lane never acknowledges: grant timeout.
    do_reset(8'b00_00_01_00, 4'b0000);
    stub = 4'b0010;
    wait_grants(1);
    repeat (200) @(negedge clk);
    chk("to_early", 32'(fault), 32'd0);
    repeat (100) @(negedge clk);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_nogrant", 32'(glog.size()), 32'd1);

    // Reset clears the fault.
    do_reset(8'b00_00_00_00, 4'b0000);
    repeat (2) @(negedge clk);
    chk("recover", 32'(fault), 32'd0);

    // Foreign lane leaves red while L1 is served.
    do_reset(8'b00_00_11_00, 4'b0000);
    wait_grants(1);
    @(negedge clk);
    @(negedge clk);
    chk("cf_pre", 32'(fault), 32'd0);
    f_notred = 4'b1000;
    @(negedge clk);
    chk("cf_fault", 32'(fault), 32'd1);

    // Green seen during clearance.
    do_reset(8'b00_00_00_00, 4'b0000);
    @(negedge clk);
    chk("cg_pre", 32'(fault), 32'd0);
    f_green = 4'b0001;
    @(negedge clk);
    chk("cg_fault", 32'(fault), 32'd1);

    do_reset(8'b00_00_00_00, 4'b0000);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
